uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 34 +++
 rtl/uart_tx_scheduler_if.sv | 25 ++
 rtl/uart_tx_scheduler_bin2bcd_seq.sv | 60 ++++++
 rtl/uart_tx_scheduler.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// rtl/uart_tx_scheduler_pkg.sv - shared types and constants for the UART TX scheduler
// Package tx_sched_pkg: FSM state enum, ASCII constants, frame length, BCD helpers.
// Optional feature macro: TX_SCHED_CRLF_EN (report frame gains trailing CR LF).
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam int unsigned BIN_W      = 14;
  localparam logic [13:0] COUNT_MAX  = 14'd9999;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;

`ifdef TX_SCHED_CRLF_EN
  localparam int unsigned FRAME_LEN = 6;
`else
  localparam int unsigned FRAME_LEN = 4;
`endif

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  // Four BCD digits, index 3 is the thousands digit.
  typedef logic [3:0][3:0] bcd_t;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - handshake between the scheduler and the UART transmitter
// Signals: tx_start (start strobe), tx_data (byte), tx_busy (shifting), tx_done (byte end strobe).
// master = scheduler side, slave = transmitter side.
interface uart_tx_scheduler_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_scheduler_bin2bcd_seq.sv
// rtl/uart_tx_scheduler_bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter
// Ports: clk, reset (async, active-high), start (load bin), bin[13:0],
//        done (1-cycle strobe when bcd is valid), bcd (4x4-bit, held until next start).
// Double-dabble: one add-3/shift step per cycle, 14 cycles after the start edge.
module bin2bcd_seq
  import tx_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output bcd_t             bcd
);

  logic [BIN_W-1:0] shift_reg;
  logic [15:0]      acc;
  logic [15:0]      adj;
  logic [3:0]       step;
  logic             busy;

  // Add 3 to every digit that is 5 or more before the next left shift.
  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      acc       <= '0;
      step      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shift_reg <= bin;
        acc       <= '0;
        step      <= '0;
        busy      <= 1'b1;
      end else if (busy) begin
        acc       <= {adj[14:0], shift_reg[BIN_W-1]};
        shift_reg <= shift_reg << 1;
        step      <= step + 4'd1;
        if (step == 4'(BIN_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - arbitrates echo bytes and count report frames onto one UART TX
// Ports: clk, reset (async, active-high); echo_req/echo_data (received byte strobe);
//        report_req (frame request strobe), count[13:0] (live counter);
//        tx (uart_tx_scheduler_if.master: tx_start, tx_data, tx_busy, tx_done);
//        echo_drop (1-cycle pulse on discarded echo byte), sched_busy (FSM not IDLE).
// Parameter ECHO_DEPTH: echo FIFO depth, power of two, >= 2.
// Macro TX_SCHED_CRLF_EN: report frame is 4 digits + CR LF instead of 4 digits.
module uart_tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int ECHO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       echo_req,
  input  logic [7:0]                 echo_data,
  input  logic                       report_req,
  input  logic [BIN_W-1:0]           count,
  uart_tx_scheduler_if.master        tx,
  output logic                       echo_drop,
  output logic                       sched_busy
);

  localparam int AW = $clog2(ECHO_DEPTH);

  state_t           state;
  logic [7:0]       fifo_mem [ECHO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             pending;
  logic             rr_report;     // 1: report wins the next tie
  logic             is_report;
  logic [2:0]       byte_idx;
  logic [2:0]       next_idx;
  logic [7:0]       tx_data_r;
  logic             can_grant;
  logic             want_echo;
  logic             want_rep;
  logic             grant_echo;
  logic             grant_rep;
  logic             more_bytes;
  logic [BIN_W-1:0] clamped;
  logic             conv_done;
  bcd_t             bcd;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input bcd_t d);
    logic [7:0] b;
    case (idx)
      3'd0:    b = digit_ascii(d[3]);
      3'd1:    b = digit_ascii(d[2]);
      3'd2:    b = digit_ascii(d[1]);
      3'd3:    b = digit_ascii(d[0]);
`ifdef TX_SCHED_CRLF_EN
      3'd4:    b = ASCII_CR;
      3'd5:    b = ASCII_LF;
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // New work is only taken while the line is free, so bytes that arrive during
  // a transmission stay in the FIFO and overflow is bounded by ECHO_DEPTH.
  assign can_grant  = (state == IDLE) && !tx.tx_busy;
  assign want_echo  = can_grant && !fifo_empty;
  assign want_rep   = can_grant && pending;
  assign grant_rep  = want_rep && (!want_echo || rr_report);
  assign grant_echo = want_echo && !grant_rep;

  assign pop  = grant_echo;
  assign push = echo_req && (!fifo_full || pop);

  assign clamped    = (count > COUNT_MAX) ? COUNT_MAX : count;
  assign next_idx   = byte_idx + 3'd1;
  assign more_bytes = is_report && (byte_idx != LAST_IDX);

  assign tx.tx_start = (state == SEND) && !tx.tx_busy;
  assign tx.tx_data  = tx_data_r;
  assign sched_busy  = (state != IDLE);

  // The report grant doubles as the converter start, so count is captured on that edge.
  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (grant_rep),
    .bin   (clamped),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= echo_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pending   <= 1'b0;
      rr_report <= 1'b1;
      is_report <= 1'b0;
      byte_idx  <= '0;
      tx_data_r <= 8'h00;
      echo_drop <= 1'b0;
    end else begin
      echo_drop <= echo_req && fifo_full && !pop;
      // A request in the grant cycle survives the clear and yields one more frame.
      pending   <= report_req || (pending && !grant_rep);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Round-robin pointer moves only on contested grants.
      if (want_echo && want_rep) rr_report <= !grant_rep;

      case (state)
        IDLE: begin
          if (grant_echo) begin
            tx_data_r <= fifo_mem[rd_ptr[AW-1:0]];
            is_report <= 1'b0;
            state     <= SEND;
          end else if (grant_rep) begin
            is_report <= 1'b1;
            byte_idx  <= '0;
            state     <= CONV;
          end
        end
        CONV: begin
          if (conv_done) begin
            tx_data_r <= frame_byte(3'd0, bcd);
            state     <= SEND;
          end
        end
        SEND: begin
          if (!tx.tx_busy) state <= WAIT;
        end
        WAIT: begin
          if (tx.tx_done) begin
            if (more_bytes) begin
              byte_idx  <= next_idx;
              tx_data_r <= frame_byte(next_idx, bcd);
              state     <= SEND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
